// File: rtl/ccu_seq_pkg.sv
// Shared types and width helpers for the multi-word add/subtract sequencer.
package ccu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } seq_state_t;

  // NWORDS must be able to hold MAX_WORDS itself, hence the +1.
  function automatic int calc_cnt_w(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  function automatic int calc_addr_w(input int max_words);
    return (max_words > 1) ? $clog2(max_words) : 1;
  endfunction

endpackage

// File: rtl/ccu_word_adder.sv
// WORD_W-bit ripple-carry adder built from two-bit slices; also exposes the
// carry into the MSB so the caller can derive signed overflow.
module ccu_word_adder #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              c_msb_in
);

  always_comb begin
    logic c;
    logic c_mid;
    c        = cin;
    c_mid    = cin;
    sum      = '0;
    cout     = 1'b0;
    c_msb_in = 1'b0;
    for (int i = 0; i < WORD_W / 2; i++) begin
      sum[2*i]   = a[2*i] ^ b[2*i] ^ c;
      c_mid      = (a[2*i] & b[2*i]) | (a[2*i] & c) | (b[2*i] & c);
      sum[2*i+1] = a[2*i+1] ^ b[2*i+1] ^ c_mid;
      c          = (a[2*i+1] & b[2*i+1]) | (a[2*i+1] & c_mid) | (b[2*i+1] & c_mid);
    end
    // After the last slice, c_mid is the carry entering bit WORD_W-1.
    cout     = c;
    c_msb_in = c_mid;
  end

endmodule

// File: rtl/ccu_mw_add_seq.sv
// Multi-word add/subtract sequencer streaming operands through one shared word adder.
// Define CCU_SEQ_FLAGS_EN to build the OVFL and ZERO flag logic; otherwise both read 0.
module ccu_mw_add_seq
  import ccu_seq_pkg::*;
#(
  parameter  int WORD_W    = 16,
  parameter  int MAX_WORDS = 8,
  localparam int CNT_W     = calc_cnt_w(MAX_WORDS),
  localparam int ADDR_W    = calc_addr_w(MAX_WORDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              OP_SUB,
  input  logic [CNT_W-1:0]  NWORDS,
  output logic              BUSY,
  output logic              DONE,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [WORD_W-1:0] RD_A,
  input  logic [WORD_W-1:0] RD_B,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [WORD_W-1:0] WR_DATA,
  output logic              CARRY_OUT,
  output logic              OVFL,
  output logic              ZERO
);

  seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]  n_q, n_clamped;
  logic [ADDR_W-1:0] rd_cnt, wr_addr_q;
  logic              op_sub_q, carry_q, carry_out_q, wr_valid;
  logic              accept, last_issue;
  logic [WORD_W-1:0] b_eff, sum;
  logic              cout;
`ifdef CCU_SEQ_FLAGS_EN
  logic              c_msb_in;
`endif

  assign n_clamped  = (NWORDS > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : NWORDS;
  assign accept     = (state == IDLE) && START;
  assign last_issue = ((CNT_W'(rd_cnt) + CNT_W'(1)) == n_q);

  // Subtraction is A + ~B with the carry register preloaded to 1.
  assign b_eff = op_sub_q ? ~RD_B : RD_B;

  ccu_word_adder #(
    .WORD_W (WORD_W)
  ) u_adder (
    .a        (RD_A),
    .b        (b_eff),
    .cin      (carry_q),
    .sum      (sum),
    .cout     (cout),
`ifdef CCU_SEQ_FLAGS_EN
    .c_msb_in (c_msb_in)
`else
    .c_msb_in ()
`endif
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = (n_clamped == '0) ? FIN : RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY    = (state == RUN) || (state == DRAIN);
    DONE    = (state == FIN);
    RD_EN   = (state == RUN);
    RD_ADDR = RD_EN ? rd_cnt : '0;
    WR_EN   = wr_valid;
    WR_ADDR = wr_valid ? wr_addr_q : '0;
    WR_DATA = wr_valid ? sum : '0;
  end

  // Read data lands one cycle after the strobe, so the write side trails the read side by one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      n_q         <= '0;
      op_sub_q    <= 1'b0;
      rd_cnt      <= '0;
      wr_addr_q   <= '0;
      wr_valid    <= 1'b0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      wr_valid <= (state == RUN);
      if (accept) begin
        n_q         <= n_clamped;
        op_sub_q    <= OP_SUB;
        rd_cnt      <= '0;
        carry_q     <= OP_SUB;
        carry_out_q <= 1'b0;
      end
      if (state == RUN) begin
        rd_cnt    <= rd_cnt + ADDR_W'(1);
        wr_addr_q <= rd_cnt;
      end
      if (wr_valid) carry_q <= cout;
      if (state == DRAIN) carry_out_q <= cout;
    end
  end

  assign CARRY_OUT = carry_out_q;

`ifdef CCU_SEQ_FLAGS_EN
  logic ovfl_q, zero_q;

  // ZERO starts true so an empty operation reports zero, then ANDs in every written word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovfl_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        ovfl_q <= 1'b0;
        zero_q <= 1'b1;
      end
      if (wr_valid) zero_q <= zero_q & (sum == '0);
      if (state == DRAIN) ovfl_q <= c_msb_in ^ cout;
    end
  end

  assign OVFL = ovfl_q;
  assign ZERO = zero_q;
`else
  assign OVFL = 1'b0;
  assign ZERO = 1'b0;
`endif

endmodule
